// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM states for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN       = 32;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic [XLEN-1:0] neg_xlen(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dxlen(input logic [2*XLEN-1:0] v);
        return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide
// on operand magnitudes, sharing one 64-bit shift register, fixed 33-cycle latency.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_e              state_r;
    state_e              state_next_s;
    logic [2:0]          op_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [2*XLEN-1:0]   acc_next_s;
    logic [XLEN-1:0]     opnd_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                neg_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;
    logic                last_iter_s;

    logic                signed_a_s;
    logic                signed_b_s;
    logic                sign_a_s;
    logic                sign_b_s;
    logic                neg_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;

    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       rem_sh_s;
    logic                div_ge_s;
    logic [XLEN-1:0]     div_diff_s;

    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     res_s;

    assign last_iter_s = (state_r == ST_CALC) && (cnt_r == CNT_W'(ITER_COUNT - 1));

    // Operand decode at start: signedness, magnitudes and final negation flag
    always_comb begin
        signed_a_s = 1'b0;
        signed_b_s = 1'b0;
        case (funct3)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b1;
            end
            OP_MULHSU: begin
                signed_a_s = 1'b1;
                signed_b_s = 1'b0;
            end
            default: begin
                signed_a_s = 1'b0;
                signed_b_s = 1'b0;
            end
        endcase
        sign_a_s = signed_a_s & operand_a[XLEN-1];
        sign_b_s = signed_b_s & operand_b[XLEN-1];
        mag_a_s  = operand_a;
        mag_b_s  = operand_b;
        if (sign_a_s) begin
            mag_a_s = neg_xlen(operand_a);
        end else begin
            mag_a_s = operand_a;
        end
        if (sign_b_s) begin
            mag_b_s = neg_xlen(operand_b);
        end else begin
            mag_b_s = operand_b;
        end
        // Divide by zero keeps the all-ones quotient unnegated; remainder follows dividend sign
        if (!funct3[2]) begin
            neg_s = sign_a_s ^ sign_b_s;
        end else if (funct3[1]) begin
            neg_s = sign_a_s;
        end else begin
            neg_s = (sign_a_s ^ sign_b_s) & (operand_b != {XLEN{1'b0}});
        end
    end

    // One multiply or divide step on the shared shift register
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                     (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        rem_sh_s   = acc_r[2*XLEN-1:XLEN-1];
        div_ge_s   = (rem_sh_s >= {1'b0, opnd_r});
        div_diff_s = rem_sh_s[XLEN-1:0] - opnd_r;
        if (op_r[2]) begin
            if (div_ge_s) begin
                acc_next_s = {div_diff_s, acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Sign correction and result selection from the final step's value
    always_comb begin
        if (neg_r) begin
            prod_s = neg_dxlen(acc_next_s);
            quot_s = neg_xlen(acc_next_s[XLEN-1:0]);
            rem_s  = neg_xlen(acc_next_s[2*XLEN-1:XLEN]);
        end else begin
            prod_s = acc_next_s;
            quot_s = acc_next_s[XLEN-1:0];
            rem_s  = acc_next_s[2*XLEN-1:XLEN];
        end
        case (op_r)
            OP_MUL:                       res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              res_s = quot_s;
            OP_REM, OP_REMU:              res_s = rem_s;
            default:                      res_s = {XLEN{1'b0}};
        endcase
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_CALC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_CALC;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration, counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 3'b000;
            acc_r    <= {(2*XLEN){1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r   <= funct3;
                        acc_r  <= {{XLEN{1'b0}}, mag_a_s};
                        opnd_r <= mag_b_s;
                        neg_r  <= neg_s;
                        cnt_r  <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_iter_s) begin
                        result_r <= res_s;
                        done_r   <= 1'b1;
                    end
                end
                ST_DONE: busy_r <= 1'b0;
                default: busy_r <= 1'b0;
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_errors;

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Reference model: RV32M semantics from 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 64'd0;
        case (f)
            3'd0: begin p = sa * sb;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    // Present start for one cycle, then scramble the inputs to exercise latching
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        funct3    = f;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        funct3    = 3'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // Called in cycle 1; returns the cycle done was seen (-1 on timeout)
    task automatic wait_done(output int lat, output int busy_low, output logic [31:0] r);
        lat      = -1;
        busy_low = 0;
        r        = 32'd0;
        for (int c = 1; c <= 45; c++) begin
            if (busy !== 1'b1) busy_low++;
            if (done === 1'b1) begin
                lat = c;
                r   = result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (result !== 32'd0) begin n_errors++; $display("FAIL reset_result got=%h exp=0", result); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [2:0]  tf [11];
        logic [31:0] ta [11];
        logic [31:0] tb [11];
        logic [31:0] te [11];
        int          lat;
        int          bl;
        logic [31:0] r;
        tf = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd4, 3'd7, 3'd4, 3'd6, 3'd2, 3'd6};
        ta = '{32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
               32'h0000_0005, 32'h0000_0005, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
               32'hFFFF_FFFB};
        tb = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002,
               32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0000_0000};
        te = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF,
               32'hFFFF_FFFB};
        for (int i = 0; i < 11; i++) begin
            issue(tf[i], ta[i], tb[i]);
            wait_done(lat, bl, r);
            n_checks += 3;
            if (r !== te[i]) begin
                n_errors++;
                $display("FAIL directed[%0d]_result f=%0d got=%h exp=%h", i, tf[i], r, te[i]);
            end
            if (lat !== 33) begin
                n_errors++;
                $display("FAIL directed[%0d]_latency got=%0d exp=33", i, lat);
            end
            if (bl !== 0) begin
                n_errors++;
                $display("FAIL directed[%0d]_busy_low_cycles got=%0d exp=0", i, bl);
            end
            @(negedge clk);
            n_checks += 3;
            if (done !== 1'b0) begin n_errors++; $display("FAIL directed[%0d]_done_pulse got=%b exp=0", i, done); end
            if (busy !== 1'b0) begin n_errors++; $display("FAIL directed[%0d]_idle_busy got=%b exp=0", i, busy); end
            if (result !== te[i]) begin
                n_errors++;
                $display("FAIL directed[%0d]_hold got=%h exp=%h", i, result, te[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [31:0] r;
        int          lat;
        int          bl;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
                3: b = {28'hFFF_FFFF, 4'($urandom)};
                default: b = b;
            endcase
            e = ref_result(f, a, b);
            issue(f, a, b);
            wait_done(lat, bl, r);
            n_checks += 2;
            if (r !== e) begin
                n_errors++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h got=%h exp=%h", i, f, a, b, r, e);
            end
            if (lat !== 33) begin
                n_errors++;
                $display("FAIL random[%0d]_latency got=%0d exp=33", i, lat);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored();
        int          first;
        int          extra;
        logic [31:0] r;
        issue(3'd5, 32'd100, 32'd7);
        for (int c = 2; c <= 10; c++) @(negedge clk);
        funct3    = 3'd0;
        operand_a = 32'd3;
        operand_b = 32'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first = -1;
        extra = 0;
        r     = 32'd0;
        for (int c = 11; c <= 90; c++) begin
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    r     = result;
                end else begin
                    extra++;
                end
            end
            @(negedge clk);
        end
        n_checks += 3;
        if (first !== 33) begin n_errors++; $display("FAIL busy_start_done_cycle got=%0d exp=33", first); end
        if (r !== 32'd14) begin n_errors++; $display("FAIL busy_start_result got=%h exp=0000000e", r); end
        if (extra !== 0) begin n_errors++; $display("FAIL busy_start_extra_done got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] e;
        logic [31:0] r;
        int          lat;
        int          bl;
        issue(3'd0, 32'h0001_2345, 32'h0000_0321);
        for (int c = 2; c <= 12; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin n_errors++; $display("FAIL abort_done got=%b exp=0", done); end
        if (result !== 32'd0) begin n_errors++; $display("FAIL abort_result got=%h exp=0", result); end
        reset = 1'b0;
        e = ref_result(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
        wait_done(lat, bl, r);
        n_checks += 2;
        if (lat !== 33) begin n_errors++; $display("FAIL after_abort_latency got=%0d exp=33", lat); end
        if (r !== e) begin n_errors++; $display("FAIL after_abort_result got=%h exp=%h", r, e); end
        @(negedge clk);
    endtask

    task automatic test_reset_priority();
        reset     = 1'b1;
        funct3    = 3'd0;
        operand_a = 32'd3;
        operand_b = 32'd4;
        start     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        n_checks += 2;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_priority_busy got=%b exp=0", busy); end
        if (result !== 32'd0) begin n_errors++; $display("FAIL reset_priority_result got=%h exp=0", result); end
        @(negedge clk);
        n_checks += 1;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_priority_busy_later got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        logic [31:0] r;
        int          lat;
        int          bl;
        f = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
        issue(f, a, b);
        for (int i = 0; i < 4; i++) begin
            wait_done(lat, bl, r);
            n_checks += 2;
            if (lat !== 33) begin n_errors++; $display("FAIL b2b[%0d]_latency got=%0d exp=33", i, lat); end
            if (r !== ref_result(f, a, b)) begin
                n_errors++;
                $display("FAIL b2b[%0d]_result got=%h exp=%h", i, r, ref_result(f, a, b));
            end
            funct3    = 3'd0;
            operand_a = 32'd9;
            operand_b = 32'd9;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_checks += 1;
            if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b[%0d]_start_in_done got=%b exp=0", i, busy); end
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i == 1) ? 32'd0 : $urandom;
            e = ref_result(f, a, b);
            issue(f, a, b);
            n_checks += 1;
            if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b[%0d]_accept got=%b exp=1", i, busy); end
        end
        wait_done(lat, bl, r);
        n_checks += 1;
        if (r !== e) begin n_errors++; $display("FAIL b2b_last_result got=%h exp=%h", r, e); end
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        clk       = 1'b0;
        reset     = 1'b1;
        start     = 1'b0;
        funct3    = 3'd0;
        operand_a = 32'd0;
        operand_b = 32'd0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_reset_priority();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
